dram_ddr_rptr_pipe: RTL and testbench

//  Parametrised, registered repeater between the DRAM controller and the DDR pad ring.
//  - Read path: valid, data and ECC.
//  - Command/write path: controls, address, write data.
//  - Both paths are retimed through STAGES flop stages with identical latency.
//  - Adds over a wire-only repeater: valid-gated data capture, idle forcing on a

---
 rtl/dram_ddr_rptr_pipe_pkg.sv | 63 ++++++
 rtl/dram_ddr_rptr_pipe_if.sv | 87 ++++++++
 rtl/dram_ddr_rptr_pipe_stage.sv | 146 ++++++++++++++
 rtl/dram_ddr_rptr_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_dram_ddr_rptr_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_ddr_rptr_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_rptr_pkg
//  Description : Shared constants and helpers for the DRAM/DDR repeater pipe.
//                - Idle values for the chip-select and command strobes.
//                - Bit map of the packed 9-bit control word carried down the
//                  command path.
//                - STAGES legality check and data-lane count helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dram_rptr_pkg;

    // Parity is computed per 32-bit lane of read data.
    localparam int c_LANE_W = 32;

    // Idle levels: all strobes are active low, so idle is 1.
    localparam logic c_CMD_IDLE    = 1'b1;
    localparam logic c_CS_IDLE_BIT = 1'b1;

    // Packed control word: one bit per scalar controller control.
    localparam int c_CTL_W       = 9;
    localparam int c_CTL_RAS_L   = 0;
    localparam int c_CTL_CAS_L   = 1;
    localparam int c_CTL_WE_L    = 2;
    localparam int c_CTL_CKE     = 3;
    localparam int c_CTL_CHDIS   = 4;
    localparam int c_CTL_DRV_DAT = 5;
    localparam int c_CTL_DRV_EN  = 6;
    localparam int c_CTL_PAD_EN  = 7;
    localparam int c_CTL_PAD_INV = 8;

    // Reset value: strobes idle, channel disabled, everything else low.
    localparam logic [c_CTL_W-1:0] c_CTL_RST =
        c_CTL_W'((int'(c_CMD_IDLE) << c_CTL_RAS_L) |
                 (int'(c_CMD_IDLE) << c_CTL_CAS_L) |
                 (int'(c_CMD_IDLE) << c_CTL_WE_L)  |
                 (1 << c_CTL_CHDIS));

    // Idle forcing on a disabled channel: strobes set high, drivers cleared.
    localparam logic [c_CTL_W-1:0] c_CTL_FORCE_SET =
        c_CTL_W'((int'(c_CMD_IDLE) << c_CTL_RAS_L) |
                 (int'(c_CMD_IDLE) << c_CTL_CAS_L) |
                 (int'(c_CMD_IDLE) << c_CTL_WE_L));
    localparam logic [c_CTL_W-1:0] c_CTL_FORCE_CLR =
        c_CTL_W'((1 << c_CTL_DRV_DAT) | (1 << c_CTL_DRV_EN));

    typedef logic [c_LANE_W-1:0] lane_t;

    function automatic bit stages_legal(input int stages);
        return (stages >= 1) && (stages <= 4);
    endfunction

    function automatic int lane_count(input int data_w);
        return data_w / c_LANE_W;
    endfunction

    // Even parity of one lane: the parity bit makes the total count of ones even.
    function automatic logic lane_parity(input lane_t lane);
        return ^lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_ddr_rptr_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : dram_ddr_rptr_pipe_if
//  Description : Bundle of the read path (pads -> controller) and the
//                command/write path (controller -> pads), raw and retimed.
//                modport master : source of the raw signals, sink of _buf
//                modport slave  : the repeater (raw in, _buf out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dram_ddr_rptr_pipe_if #(
    parameter int DATA_W  = 256,
    parameter int ECC_W   = 32,
    parameter int WDATA_W = 288,
    parameter int ADDR_W  = 15,
    parameter int BANK_W  = 3,
    parameter int CS_W    = 4,
    parameter int PCLK_W  = 5
);
    // Read path
    logic                io_dram_data_valid;
    logic [DATA_W-1:0]   io_dram_data_in;
    logic [ECC_W-1:0]    io_dram_ecc_in;
    logic                io_dram_data_valid_buf;
    logic [DATA_W-1:0]   io_dram_data_in_buf;
    logic [ECC_W-1:0]    io_dram_ecc_in_buf;

    // Command / write path
    logic                dram_io_ras_l;
    logic                dram_io_cas_l;
    logic                dram_io_write_en_l;
    logic                dram_io_cke;
    logic                dram_io_channel_disabled;
    logic                dram_io_drive_data;
    logic                dram_io_drive_enable;
    logic                dram_io_pad_enable;
    logic                dram_io_pad_clk_inv;
    logic [ADDR_W-1:0]   dram_io_addr;
    logic [BANK_W-1:0]   dram_io_bank;
    logic [CS_W-1:0]     dram_io_cs_l;
    logic [WDATA_W-1:0]  dram_io_data_out;
    logic [PCLK_W-1:0]   dram_io_ptr_clk_inv;

    logic                dram_io_ras_l_buf;
    logic                dram_io_cas_l_buf;
    logic                dram_io_write_en_l_buf;
    logic                dram_io_cke_buf;
    logic                dram_io_channel_disabled_buf;
    logic                dram_io_drive_data_buf;
    logic                dram_io_drive_enable_buf;
    logic                dram_io_pad_enable_buf;
    logic                dram_io_pad_clk_inv_buf;
    logic [ADDR_W-1:0]   dram_io_addr_buf;
    logic [BANK_W-1:0]   dram_io_bank_buf;
    logic [CS_W-1:0]     dram_io_cs_l_buf;
    logic [WDATA_W-1:0]  dram_io_data_out_buf;
    logic [PCLK_W-1:0]   dram_io_ptr_clk_inv_buf;

    modport master (
        output io_dram_data_valid, io_dram_data_in, io_dram_ecc_in,
        output dram_io_ras_l, dram_io_cas_l, dram_io_write_en_l, dram_io_cke,
               dram_io_channel_disabled, dram_io_drive_data, dram_io_drive_enable,
               dram_io_pad_enable, dram_io_pad_clk_inv, dram_io_addr, dram_io_bank,
               dram_io_cs_l, dram_io_data_out, dram_io_ptr_clk_inv,
        input  io_dram_data_valid_buf, io_dram_data_in_buf, io_dram_ecc_in_buf,
        input  dram_io_ras_l_buf, dram_io_cas_l_buf, dram_io_write_en_l_buf,
               dram_io_cke_buf, dram_io_channel_disabled_buf, dram_io_drive_data_buf,
               dram_io_drive_enable_buf, dram_io_pad_enable_buf, dram_io_pad_clk_inv_buf,
               dram_io_addr_buf, dram_io_bank_buf, dram_io_cs_l_buf,
               dram_io_data_out_buf, dram_io_ptr_clk_inv_buf
    );

    modport slave (
        input  io_dram_data_valid, io_dram_data_in, io_dram_ecc_in,
        input  dram_io_ras_l, dram_io_cas_l, dram_io_write_en_l, dram_io_cke,
               dram_io_channel_disabled, dram_io_drive_data, dram_io_drive_enable,
               dram_io_pad_enable, dram_io_pad_clk_inv, dram_io_addr, dram_io_bank,
               dram_io_cs_l, dram_io_data_out, dram_io_ptr_clk_inv,
        output io_dram_data_valid_buf, io_dram_data_in_buf, io_dram_ecc_in_buf,
        output dram_io_ras_l_buf, dram_io_cas_l_buf, dram_io_write_en_l_buf,
               dram_io_cke_buf, dram_io_channel_disabled_buf, dram_io_drive_data_buf,
               dram_io_drive_enable_buf, dram_io_pad_enable_buf, dram_io_pad_clk_inv_buf,
               dram_io_addr_buf, dram_io_bank_buf, dram_io_cs_l_buf,
               dram_io_data_out_buf, dram_io_ptr_clk_inv_buf
    );

endinterface
`default_nettype wire

// File: rtl/dram_ddr_rptr_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dram_rptr_stage
//  Description : One retiming stage of the repeater.
//                - Read path: valid shifts every cycle; data/ecc (and lane
//                  parity when RPTR_PAR_EN is defined) load only on valid.
//                - Command path: free-running flops. With IDLE_FORCE set, a
//                  disabled channel is captured as idle (cs_l all ones,
//                  strobes high, drive_data/drive_enable low).
//  Ports       : clk, arst_l (async, active low)
//                i_valid/i_data/i_ecc[/i_par]   -> o_valid/o_data/o_ecc[/o_par]
//                i_ctl/i_addr/i_bank/i_cs_l/i_wdata/i_pclk -> o_* retimed copies
//  Config      : RPTR_PAR_EN adds the lane-parity flops
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_rptr_stage
    import dram_rptr_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int ECC_W      = 32,
    parameter int WDATA_W    = 288,
    parameter int ADDR_W     = 15,
    parameter int BANK_W     = 3,
    parameter int CS_W       = 4,
    parameter int PCLK_W     = 5,
    parameter bit IDLE_FORCE = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               arst_l,

    input  wire logic               i_valid,
    input  wire logic [DATA_W-1:0]  i_data,
    input  wire logic [ECC_W-1:0]   i_ecc,
`ifdef RPTR_PAR_EN
    input  wire logic [lane_count(DATA_W)-1:0] i_par,
    output logic      [lane_count(DATA_W)-1:0] o_par,
`endif
    output logic                    o_valid,
    output logic      [DATA_W-1:0]  o_data,
    output logic      [ECC_W-1:0]   o_ecc,

    input  wire logic [c_CTL_W-1:0] i_ctl,
    input  wire logic [ADDR_W-1:0]  i_addr,
    input  wire logic [BANK_W-1:0]  i_bank,
    input  wire logic [CS_W-1:0]    i_cs_l,
    input  wire logic [WDATA_W-1:0] i_wdata,
    input  wire logic [PCLK_W-1:0]  i_pclk,
    output logic      [c_CTL_W-1:0] o_ctl,
    output logic      [ADDR_W-1:0]  o_addr,
    output logic      [BANK_W-1:0]  o_bank,
    output logic      [CS_W-1:0]    o_cs_l,
    output logic      [WDATA_W-1:0] o_wdata,
    output logic      [PCLK_W-1:0]  o_pclk
);

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ECC_W-1:0]  r_ecc;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ecc   <= '0;
        end else begin
            r_valid <= i_valid;
            // Hold payload on idle cycles to save toggling downstream.
            if (i_valid) begin
                r_data <= i_data;
                r_ecc  <= i_ecc;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ecc   = r_ecc;

`ifdef RPTR_PAR_EN
    logic [lane_count(DATA_W)-1:0] r_par;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_par <= '0;
        end else if (i_valid) begin
            r_par <= i_par;
        end
    end

    assign o_par = r_par;
`endif

    // ------------------------------------------------------------------
    // Command / write path
    // ------------------------------------------------------------------
    logic               w_force;
    logic [c_CTL_W-1:0] w_ctl;
    logic [CS_W-1:0]    w_cs_l;

    always_comb begin
        w_force = IDLE_FORCE && i_ctl[c_CTL_CHDIS];
        w_ctl   = i_ctl;
        w_cs_l  = i_cs_l;
        if (w_force) begin
            w_ctl  = (i_ctl | c_CTL_FORCE_SET) & ~c_CTL_FORCE_CLR;
            w_cs_l = {CS_W{c_CS_IDLE_BIT}};
        end
    end

    logic [c_CTL_W-1:0] r_ctl;
    logic [ADDR_W-1:0]  r_addr;
    logic [BANK_W-1:0]  r_bank;
    logic [CS_W-1:0]    r_cs_l;
    logic [WDATA_W-1:0] r_wdata;
    logic [PCLK_W-1:0]  r_pclk;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_ctl   <= c_CTL_RST;
            r_addr  <= '0;
            r_bank  <= '0;
            r_cs_l  <= {CS_W{c_CS_IDLE_BIT}};
            r_wdata <= '0;
            r_pclk  <= '0;
        end else begin
            r_ctl   <= w_ctl;
            r_addr  <= i_addr;
            r_bank  <= i_bank;
            r_cs_l  <= w_cs_l;
            r_wdata <= i_wdata;
            r_pclk  <= i_pclk;
        end
    end

    assign o_ctl   = r_ctl;
    assign o_addr  = r_addr;
    assign o_bank  = r_bank;
    assign o_cs_l  = r_cs_l;
    assign o_wdata = r_wdata;
    assign o_pclk  = r_pclk;

endmodule
`default_nettype wire

// File: rtl/dram_ddr_rptr_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dram_ddr_rptr_pipe
//  Description : Registered repeater between the DRAM controller and the DDR
//                pad ring. Read and command paths are retimed through STAGES
//                identical stages (latency = STAGES cycles on every field).
//                Stage 0 forces idle commands on a disabled channel. A prime
//                counter flags when the pipe has filled after reset.
//  Ports       : clk         core clock
//                arst_l      async reset, active low
//                bus         dram_ddr_rptr_pipe_if.slave (raw in, _buf out)
//                rptr_primed high once STAGES cycles elapsed after reset
//                rptr_par_err sticky read-path lane parity error
//                             (present only with RPTR_PAR_EN)
//  Config      : RPTR_PAR_EN - per-lane even parity generate/check
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_ddr_rptr_pipe
    import dram_rptr_pkg::*;
#(
    parameter int STAGES  = 1,
    parameter int DATA_W  = 256,
    parameter int ECC_W   = 32,
    parameter int WDATA_W = 288,
    parameter int ADDR_W  = 15,
    parameter int BANK_W  = 3,
    parameter int CS_W    = 4,
    parameter int PCLK_W  = 5
) (
    input  wire logic            clk,
    input  wire logic            arst_l,
    dram_ddr_rptr_pipe_if.slave  bus,
    output logic                 rptr_primed
`ifdef RPTR_PAR_EN
    ,
    output logic                 rptr_par_err
`endif
);

    generate
        if (!stages_legal(STAGES)) begin : g_bad_stages
            $error("dram_ddr_rptr_pipe: STAGES must be in 1..4");
        end
        if ((DATA_W % c_LANE_W) != 0) begin : g_bad_data_w
            $error("dram_ddr_rptr_pipe: DATA_W must be a multiple of 32");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage chain: index 0 is the raw input, index STAGES the output.
    // ------------------------------------------------------------------
    logic               w_valid [0:STAGES];
    logic [DATA_W-1:0]  w_data  [0:STAGES];
    logic [ECC_W-1:0]   w_ecc   [0:STAGES];
    logic [c_CTL_W-1:0] w_ctl   [0:STAGES];
    logic [ADDR_W-1:0]  w_addr  [0:STAGES];
    logic [BANK_W-1:0]  w_bank  [0:STAGES];
    logic [CS_W-1:0]    w_cs_l  [0:STAGES];
    logic [WDATA_W-1:0] w_wdata [0:STAGES];
    logic [PCLK_W-1:0]  w_pclk  [0:STAGES];

    assign w_valid[0] = bus.io_dram_data_valid;
    assign w_data[0]  = bus.io_dram_data_in;
    assign w_ecc[0]   = bus.io_dram_ecc_in;
    assign w_ctl[0]   = {bus.dram_io_pad_clk_inv,
                         bus.dram_io_pad_enable,
                         bus.dram_io_drive_enable,
                         bus.dram_io_drive_data,
                         bus.dram_io_channel_disabled,
                         bus.dram_io_cke,
                         bus.dram_io_write_en_l,
                         bus.dram_io_cas_l,
                         bus.dram_io_ras_l};
    assign w_addr[0]  = bus.dram_io_addr;
    assign w_bank[0]  = bus.dram_io_bank;
    assign w_cs_l[0]  = bus.dram_io_cs_l;
    assign w_wdata[0] = bus.dram_io_data_out;
    assign w_pclk[0]  = bus.dram_io_ptr_clk_inv;

`ifdef RPTR_PAR_EN
    localparam int PAR_W = lane_count(DATA_W);

    logic [PAR_W-1:0] w_par [0:STAGES];

    // Lane parity generated at the input, before any retiming.
    always_comb begin
        w_par[0] = '0;
        for (int l = 0; l < PAR_W; l++) begin
            w_par[0][l] = lane_parity(bus.io_dram_data_in[l*c_LANE_W +: c_LANE_W]);
        end
    end
`endif

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            dram_rptr_stage #(
                .DATA_W     (DATA_W),
                .ECC_W      (ECC_W),
                .WDATA_W    (WDATA_W),
                .ADDR_W     (ADDR_W),
                .BANK_W     (BANK_W),
                .CS_W       (CS_W),
                .PCLK_W     (PCLK_W),
                .IDLE_FORCE (k == 0)
            ) u_stage (
                .clk     (clk),
                .arst_l  (arst_l),
                .i_valid (w_valid[k]),
                .i_data  (w_data[k]),
                .i_ecc   (w_ecc[k]),
`ifdef RPTR_PAR_EN
                .i_par   (w_par[k]),
                .o_par   (w_par[k+1]),
`endif
                .o_valid (w_valid[k+1]),
                .o_data  (w_data[k+1]),
                .o_ecc   (w_ecc[k+1]),
                .i_ctl   (w_ctl[k]),
                .i_addr  (w_addr[k]),
                .i_bank  (w_bank[k]),
                .i_cs_l  (w_cs_l[k]),
                .i_wdata (w_wdata[k]),
                .i_pclk  (w_pclk[k]),
                .o_ctl   (w_ctl[k+1]),
                .o_addr  (w_addr[k+1]),
                .o_bank  (w_bank[k+1]),
                .o_cs_l  (w_cs_l[k+1]),
                .o_wdata (w_wdata[k+1]),
                .o_pclk  (w_pclk[k+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.io_dram_data_valid_buf       = w_valid[STAGES];
    assign bus.io_dram_data_in_buf          = w_data[STAGES];
    assign bus.io_dram_ecc_in_buf           = w_ecc[STAGES];
    assign bus.dram_io_ras_l_buf            = w_ctl[STAGES][c_CTL_RAS_L];
    assign bus.dram_io_cas_l_buf            = w_ctl[STAGES][c_CTL_CAS_L];
    assign bus.dram_io_write_en_l_buf       = w_ctl[STAGES][c_CTL_WE_L];
    assign bus.dram_io_cke_buf              = w_ctl[STAGES][c_CTL_CKE];
    assign bus.dram_io_channel_disabled_buf = w_ctl[STAGES][c_CTL_CHDIS];
    assign bus.dram_io_drive_data_buf       = w_ctl[STAGES][c_CTL_DRV_DAT];
    assign bus.dram_io_drive_enable_buf     = w_ctl[STAGES][c_CTL_DRV_EN];
    assign bus.dram_io_pad_enable_buf       = w_ctl[STAGES][c_CTL_PAD_EN];
    assign bus.dram_io_pad_clk_inv_buf      = w_ctl[STAGES][c_CTL_PAD_INV];
    assign bus.dram_io_addr_buf             = w_addr[STAGES];
    assign bus.dram_io_bank_buf             = w_bank[STAGES];
    assign bus.dram_io_cs_l_buf             = w_cs_l[STAGES];
    assign bus.dram_io_data_out_buf         = w_wdata[STAGES];
    assign bus.dram_io_ptr_clk_inv_buf      = w_pclk[STAGES];

    // ------------------------------------------------------------------
    // Prime counter: counts edges since reset release, saturating at
    // STAGES, so primed tracks "every stage now holds post-reset data".
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] c_PRIME_MAX = CNT_W'(STAGES);

    logic [CNT_W-1:0] r_prime_cnt;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_prime_cnt <= '0;
        end else if (r_prime_cnt != c_PRIME_MAX) begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
        end
    end

    assign rptr_primed = (r_prime_cnt == c_PRIME_MAX);

`ifdef RPTR_PAR_EN
    // ------------------------------------------------------------------
    // Output-side parity check, only on cycles carrying valid data.
    // ------------------------------------------------------------------
    logic [PAR_W-1:0] w_par_chk;
    logic             w_par_mis;
    logic             r_par_err;

    always_comb begin
        w_par_chk = '0;
        for (int l = 0; l < PAR_W; l++) begin
            w_par_chk[l] = lane_parity(w_data[STAGES][l*c_LANE_W +: c_LANE_W]);
        end
        w_par_mis = w_valid[STAGES] && (w_par_chk != w_par[STAGES]);
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_par_err <= 1'b0;
        end else if (w_par_mis) begin
            r_par_err <= 1'b1;
        end
    end

    assign rptr_par_err = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_ddr_rptr_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_ddr_rptr_pipe
//  Description : Self-checking bench for dram_ddr_rptr_pipe with STAGES=3.
//                Table of streamed vectors plus hand-written sequences for
//                priming, single pulse, burst, mid-burst reset and (with
//                RPTR_PAR_EN) parity error injection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_ddr_rptr_pipe;

    localparam int STAGES = 3;
    localparam int NV     = 7;

    logic clk    = 1'b0;
    logic arst_l = 1'b0;
    always #5 clk = ~clk;

    dram_ddr_rptr_pipe_if bus ();
    logic rptr_primed;
`ifdef RPTR_PAR_EN
    logic rptr_par_err;
`endif

    dram_ddr_rptr_pipe #(.STAGES(STAGES)) dut (
        .clk         (clk),
        .arst_l      (arst_l),
        .bus         (bus),
        .rptr_primed (rptr_primed)
`ifdef RPTR_PAR_EN
        ,
        .rptr_par_err(rptr_par_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [31:0] e;
        logic        chdis;
        logic [3:0]  cs;
        logic        ras;
        logic        de;
        logic [14:0] addr;
        logic        xv;
        logic [31:0] xd;
        logic [31:0] xe;
        logic [3:0]  xcs;
        logic        xras;
        logic        xde;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // cas_l/write_en_l follow ras_l, drive_data follows drive_enable, and the
    // remaining fields are derived from data/addr so every field is exercised.
    task automatic drive(input logic v, input logic [31:0] dw, input logic [31:0] e,
                         input logic chdis, input logic [3:0] cs, input logic ras,
                         input logic de, input logic [14:0] addr);
        bus.io_dram_data_valid       = v;
        bus.io_dram_data_in          = {8{dw}};
        bus.io_dram_ecc_in           = e;
        bus.dram_io_channel_disabled = chdis;
        bus.dram_io_cs_l             = cs;
        bus.dram_io_ras_l            = ras;
        bus.dram_io_cas_l            = ras;
        bus.dram_io_write_en_l       = ras;
        bus.dram_io_drive_enable     = de;
        bus.dram_io_drive_data       = de;
        bus.dram_io_cke              = 1'b1;
        bus.dram_io_pad_enable       = 1'b1;
        bus.dram_io_pad_clk_inv      = addr[0];
        bus.dram_io_addr             = addr;
        bus.dram_io_bank             = addr[2:0];
        bus.dram_io_data_out         = {9{dw}};
        bus.dram_io_ptr_clk_inv      = addr[4:0];
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b1, 15'h0);
    endtask

    task automatic check_vec(input int i, input vec_t x);
        chk($sformatf("v%0d valid_buf", i), bus.io_dram_data_valid_buf, x.xv);
        chk($sformatf("v%0d data_buf", i), bus.io_dram_data_in_buf, {8{x.xd}});
        chk($sformatf("v%0d ecc_buf", i), bus.io_dram_ecc_in_buf, x.xe);
        chk($sformatf("v%0d cs_l_buf", i), bus.dram_io_cs_l_buf, x.xcs);
        chk($sformatf("v%0d ras_l_buf", i), bus.dram_io_ras_l_buf, x.xras);
        chk($sformatf("v%0d cas_l_buf", i), bus.dram_io_cas_l_buf, x.xras);
        chk($sformatf("v%0d we_l_buf", i), bus.dram_io_write_en_l_buf, x.xras);
        chk($sformatf("v%0d drv_en_buf", i), bus.dram_io_drive_enable_buf, x.xde);
        chk($sformatf("v%0d drv_dat_buf", i), bus.dram_io_drive_data_buf, x.xde);
        chk($sformatf("v%0d chdis_buf", i), bus.dram_io_channel_disabled_buf, x.chdis);
        chk($sformatf("v%0d cke_buf", i), bus.dram_io_cke_buf, 1'b1);
        chk($sformatf("v%0d pad_en_buf", i), bus.dram_io_pad_enable_buf, 1'b1);
        chk($sformatf("v%0d pad_inv_buf", i), bus.dram_io_pad_clk_inv_buf, x.addr[0]);
        chk($sformatf("v%0d addr_buf", i), bus.dram_io_addr_buf, x.addr);
        chk($sformatf("v%0d bank_buf", i), bus.dram_io_bank_buf, x.addr[2:0]);
        chk($sformatf("v%0d wdata_buf", i), bus.dram_io_data_out_buf, {9{x.d}});
        chk($sformatf("v%0d pclk_buf", i), bus.dram_io_ptr_clk_inv_buf, x.addr[4:0]);
    endtask

    initial begin
        logic [255:0] a5;
        a5 = {8{32'hA5A5A5A5}};

        //            v  data          ecc           chd cs    ras de addr      | xv xdata         xecc          xcs  xras xde
        vecs[0] = '{1'b1, 32'hA5A5A5A5, 32'h11111111, 1'b0, 4'hE, 1'b0, 1'b1, 15'h0001, 1'b1, 32'hA5A5A5A5, 32'h11111111, 4'hE, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'h00000001, 32'h22222222, 1'b0, 4'hD, 1'b1, 1'b0, 15'h7FFF, 1'b1, 32'h00000001, 32'h22222222, 4'hD, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'hDEADBEEF, 32'h33333333, 1'b0, 4'hB, 1'b0, 1'b1, 15'h0ABC, 1'b0, 32'h00000001, 32'h22222222, 4'hB, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 4'h0, 1'b0, 1'b1, 15'h1234, 1'b0, 32'h00000001, 32'h22222222, 4'hF, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h12345678, 32'h44444444, 1'b1, 4'h0, 1'b0, 1'b1, 15'h4321, 1'b1, 32'h12345678, 32'h44444444, 4'hF, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'h55555555, 1'b0, 4'h7, 1'b0, 1'b1, 15'h0000, 1'b1, 32'hFFFFFFFF, 32'h55555555, 4'h7, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'h00000000, 32'h00000000, 1'b0, 4'hF, 1'b1, 1'b0, 15'h0000, 1'b0, 32'hFFFFFFFF, 32'h55555555, 4'hF, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst valid_buf", bus.io_dram_data_valid_buf, 1'b0);
        chk("rst data_buf", bus.io_dram_data_in_buf, '0);
        chk("rst ecc_buf", bus.io_dram_ecc_in_buf, '0);
        chk("rst cs_l_buf", bus.dram_io_cs_l_buf, 4'hF);
        chk("rst ras_l_buf", bus.dram_io_ras_l_buf, 1'b1);
        chk("rst cas_l_buf", bus.dram_io_cas_l_buf, 1'b1);
        chk("rst we_l_buf", bus.dram_io_write_en_l_buf, 1'b1);
        chk("rst chdis_buf", bus.dram_io_channel_disabled_buf, 1'b1);
        chk("rst cke_buf", bus.dram_io_cke_buf, 1'b0);
        chk("rst drv_en_buf", bus.dram_io_drive_enable_buf, 1'b0);
        chk("rst drv_dat_buf", bus.dram_io_drive_data_buf, 1'b0);
        chk("rst pad_en_buf", bus.dram_io_pad_enable_buf, 1'b0);
        chk("rst pad_inv_buf", bus.dram_io_pad_clk_inv_buf, 1'b0);
        chk("rst addr_buf", bus.dram_io_addr_buf, 15'h0);
        chk("rst bank_buf", bus.dram_io_bank_buf, 3'h0);
        chk("rst wdata_buf", bus.dram_io_data_out_buf, '0);
        chk("rst pclk_buf", bus.dram_io_ptr_clk_inv_buf, 5'h0);
        chk("rst primed", rptr_primed, 1'b0);

        // ---------------- priming with idle inputs ----------------
        arst_l = 1'b1;
        for (int k = 1; k <= STAGES + 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("prime edge%0d primed", k), rptr_primed, (k >= STAGES));
            chk($sformatf("prime edge%0d cs_l_buf", k), bus.dram_io_cs_l_buf, 4'hF);
            chk($sformatf("prime edge%0d chdis_buf", k), bus.dram_io_channel_disabled_buf, 1'b1);
        end

        // ---------------- streamed table ----------------
        for (int j = 0; j < NV + STAGES; j++) begin
            @(negedge clk);
            if (j >= STAGES) check_vec(j - STAGES, vecs[j - STAGES]);
            if (j < NV) drive(vecs[j].v, vecs[j].d, vecs[j].e, vecs[j].chdis, vecs[j].cs,
                              vecs[j].ras, vecs[j].de, vecs[j].addr);
            else        drive_idle();
        end

        // ---------------- single valid pulse ----------------
        @(negedge clk);
        drive(1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 15'h0);
        for (int k = 1; k <= STAGES + 2; k++) begin
            @(negedge clk);
            chk($sformatf("pulse cyc%0d valid_buf", k), bus.io_dram_data_valid_buf, (k == STAGES));
            if (k == STAGES) chk("pulse data_buf", bus.io_dram_data_in_buf, a5);
            if (k == 1) drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 15'h0);
        end
        chk("pulse data held", bus.io_dram_data_in_buf, a5);

        // ---------------- 16-beat back-to-back burst ----------------
        for (int j = 0; j < 16 + STAGES + 2; j++) begin
            logic exp_v;
            @(negedge clk);
            exp_v = (j >= STAGES) && (j < 16 + STAGES);
            chk($sformatf("burst cyc%0d valid_buf", j), bus.io_dram_data_valid_buf, exp_v);
            if (exp_v) chk($sformatf("burst cyc%0d data_buf", j), bus.io_dram_data_in_buf,
                           {8{32'(j - STAGES + 1)}});
            if (j < 16) drive(1'b1, 32'(j + 1), 32'(j), 1'b0, 4'h3, 1'b0, 1'b1, 15'(j));
            else        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h3, 1'b0, 1'b1, 15'h0);
        end

        // ---------------- async reset mid-burst ----------------
        for (int j = 0; j < STAGES + 2; j++) begin
            @(negedge clk);
            drive(1'b1, 32'h100 + 32'(j), 32'h0, 1'b0, 4'h3, 1'b0, 1'b1, 15'h0);
        end
        @(posedge clk);
        #1;
        chk("pre-rst valid_buf", bus.io_dram_data_valid_buf, 1'b1);
        chk("pre-rst cs_l_buf", bus.dram_io_cs_l_buf, 4'h3);
        #1;
        arst_l = 1'b0;
        #1;
        chk("mid-rst valid_buf", bus.io_dram_data_valid_buf, 1'b0);
        chk("mid-rst cs_l_buf", bus.dram_io_cs_l_buf, 4'hF);
        chk("mid-rst primed", rptr_primed, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h200, 32'h0, 1'b0, 4'h3, 1'b0, 1'b1, 15'h0);
        arst_l = 1'b1;
        for (int k = 1; k <= STAGES + 1; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("refill edge%0d valid_buf", k), bus.io_dram_data_valid_buf, (k >= STAGES));
            chk($sformatf("refill edge%0d primed", k), rptr_primed, (k >= STAGES));
        end
        chk("refill data_buf", bus.io_dram_data_in_buf, {8{32'h200}});

`ifdef RPTR_PAR_EN
        // ---------------- parity error injection ----------------
        begin
            logic [255:0] bad;
            bad = a5 ^ (256'd1 << 37);
            chk("par clean", rptr_par_err, 1'b0);
            @(negedge clk);
            drive(1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 4'h3, 1'b0, 1'b1, 15'h0);
            @(posedge clk);
            #1;
            force dut.g_stage[0].u_stage.r_data = bad;
            drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h3, 1'b0, 1'b1, 15'h0);
            @(posedge clk);
            #1;
            release dut.g_stage[0].u_stage.r_data;
            @(posedge clk);
            #1;
            chk("par out valid_buf", bus.io_dram_data_valid_buf, 1'b1);
            chk("par err not yet", rptr_par_err, 1'b0);
            @(posedge clk);
            #1;
            chk("par err set", rptr_par_err, 1'b1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                drive(1'b1, 32'h0F0F0F0F, 32'h0, 1'b0, 4'h3, 1'b0, 1'b1, 15'h0);
                @(posedge clk);
                #1;
                chk($sformatf("par err sticky%0d", k), rptr_par_err, 1'b1);
            end
            arst_l = 1'b0;
            #1;
            chk("par err cleared", rptr_par_err, 1'b0);
            @(negedge clk);
            arst_l = 1'b1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
